vga_display_sequencer: RTL and testbench

//  Frame-synchronous display-mode controller for the snake VGA pixel path.
//  - Turns game_status plus win flags into a registered display mode: blank, play field, freeze-flash or winner banner.
//  - Mode changes only at frame boundaries, so no frame tears. The DIE delay is counted in frames, not clocks.
//  - Gives the game FSM a restart_ok handshake once the banner has been shown long enough.

---
 rtl/snake_disp_pkg.sv | 36 +++
 rtl/vga_frame_tick.sv | 22 ++
 rtl/vga_display_sequencer.sv | 132 +++++++++++++
 tb/tb_vga_display_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_disp_pkg.sv
// Shared display-path types: game status, display mode, winner encoding and colours.
package snake_disp_pkg;

  typedef enum logic [1:0] {
    RESTART = 2'b00,
    START   = 2'b01,
    PLAY    = 2'b10,
    DIE     = 2'b11
  } game_status_e;

  typedef enum logic [1:0] {
    BLANK  = 2'b00,
    FIELD  = 2'b01,
    FREEZE = 2'b10,
    BANNER = 2'b11
  } disp_mode_e;

  typedef enum logic [1:0] {
    NONE  = 2'b00,
    GREEN = 2'b01,
    RED   = 2'b10,
    DRAW  = 2'b11
  } winner_e;

  // 12-bit RGB444 palette used by the VGA control block.
  localparam logic [11:0] COLOR_BLACK = 12'h000;
  localparam logic [11:0] COLOR_WHITE = 12'hFFF;
  localparam logic [11:0] COLOR_GREEN = 12'h0F0;
  localparam logic [11:0] COLOR_RED   = 12'hF00;
  localparam logic [11:0] COLOR_APPLE = 12'hF80;

  function automatic winner_e decode_winner(input logic red_flag, input logic green_flag);
    return winner_e'({red_flag, green_flag});
  endfunction

endpackage

// File: rtl/vga_frame_tick.sv
// Registered falling-edge detect on active-low vsync: one-cycle frame_start per frame,
// one clk after the sampled fall; no backpressure, a held-low vsync yields a single pulse.
module vga_frame_tick (
  input  logic clk,
  input  logic rst,
  input  logic vga_vs,
  output logic frame_start
);

  logic vs_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_q        <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      vs_q        <= vga_vs;
      frame_start <= vs_q & ~vga_vs;
    end
  end

endmodule

// File: rtl/vga_display_sequencer.sv
// Frame-synchronous display-mode FSM: inputs sampled on frame_start, outputs update the next clk;
// no backpressure, restart_ok tells the game FSM when the winner banner may be left.
module vga_display_sequencer
  import snake_disp_pkg::*;
#(
  parameter int FREEZE_FRAMES     = 60,
  parameter int BLINK_HALF        = 8,
  parameter int BANNER_MIN_FRAMES = 120,
  parameter int CNT_W             = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vga_vs,
  input  logic [1:0] game_status,
  input  logic       green_win,
  input  logic       red_win,
  output logic [1:0] disp_mode,
  output logic [1:0] winner,
  output logic       snake_vis,
  output logic       restart_ok,
  output logic       frame_start
);

  localparam logic [CNT_W-1:0] FREEZE_LAST = CNT_W'(FREEZE_FRAMES - 1);
  localparam logic [CNT_W-1:0] BLINK_LAST  = CNT_W'(BLINK_HALF - 1);
  localparam logic [CNT_W-1:0] BANNER_CAP  = CNT_W'(BANNER_MIN_FRAMES);

  disp_mode_e       mode_q, mode_d;
  winner_e          winner_q, winner_d;
  logic             vis_q, vis_d;
  logic             rok_q, rok_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;

  vga_frame_tick u_frame_tick (
    .clk         (clk),
    .rst         (rst),
    .vga_vs      (vga_vs),
    .frame_start (frame_start)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q      <= BLANK;
      winner_q    <= NONE;
      vis_q       <= 1'b1;
      rok_q       <= 1'b0;
      frame_cnt_q <= '0;
      blink_cnt_q <= '0;
    end else begin
      mode_q      <= mode_d;
      winner_q    <= winner_d;
      vis_q       <= vis_d;
      rok_q       <= rok_d;
      frame_cnt_q <= frame_cnt_d;
      blink_cnt_q <= blink_cnt_d;
    end
  end

  always_comb begin
    mode_d      = mode_q;
    winner_d    = winner_q;
    vis_d       = vis_q;
    rok_d       = rok_q;
    frame_cnt_d = frame_cnt_q;
    blink_cnt_d = blink_cnt_q;

    if (frame_start) begin
      case (game_status)
        RESTART: begin
          mode_d      = BLANK;
          winner_d    = NONE;
          vis_d       = 1'b1;
          rok_d       = 1'b0;
          frame_cnt_d = '0;
          blink_cnt_d = '0;
        end
        START, PLAY: begin
          if (mode_q != FIELD) begin
            mode_d      = FIELD;
            winner_d    = NONE;
            vis_d       = 1'b1;
            rok_d       = 1'b0;
            frame_cnt_d = '0;
            blink_cnt_d = '0;
          end
        end
        DIE: begin
          case (mode_q)
            BLANK, FIELD: begin
              mode_d      = FREEZE;
              winner_d    = decode_winner(red_win, green_win);
              vis_d       = 1'b1;
              rok_d       = 1'b0;
              frame_cnt_d = '0;
              blink_cnt_d = '0;
            end
            FREEZE: begin
              if (frame_cnt_q == FREEZE_LAST) begin
                mode_d      = BANNER;
                vis_d       = 1'b1;
                frame_cnt_d = '0;
                blink_cnt_d = '0;
              end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
                if (blink_cnt_q == BLINK_LAST) begin
                  blink_cnt_d = '0;
                  vis_d       = ~vis_q;
                end else begin
                  blink_cnt_d = blink_cnt_q + 1'b1;
                end
              end
            end
            BANNER: begin
              // Saturating count; restart_ok latches once the cap is reached.
              if (frame_cnt_q != BANNER_CAP) frame_cnt_d = frame_cnt_q + 1'b1;
              if (frame_cnt_d == BANNER_CAP) rok_d = 1'b1;
            end
            default: mode_d = BLANK;
          endcase
        end
        default: mode_d = BLANK;
      endcase
    end
  end

  assign disp_mode  = mode_q;
  assign winner     = winner_q;
  assign snake_vis  = vis_q;
  assign restart_ok = rok_q;

endmodule

// File: tb/tb_vga_display_sequencer.sv
// Randomized bench for vga_display_sequencer with a frame-level reference model.
module tb_vga_display_sequencer;

  localparam int FF = 4;
  localparam int BH = 2;
  localparam int BM = 3;
  localparam int CW = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       vga_vs;
  logic [1:0] game_status;
  logic       green_win;
  logic       red_win;
  logic [1:0] disp_mode;
  logic [1:0] winner;
  logic       snake_vis;
  logic       restart_ok;
  logic       frame_start;

  int checks = 0;
  int errors = 0;

  // Reference model state: what the outputs should show, and how many DIE frames
  // have been evaluated since the DIE episode began (-1 = not in a DIE episode).
  logic [1:0] m_mode;
  logic [1:0] m_win;
  logic       m_vis;
  logic       m_rok;
  int         m_k;

  logic       fs_pre, fs_post;
  logic [1:0] mode_pre;

  always #5 clk = ~clk;

  vga_display_sequencer #(
    .FREEZE_FRAMES     (FF),
    .BLINK_HALF        (BH),
    .BANNER_MIN_FRAMES (BM),
    .CNT_W             (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .vga_vs      (vga_vs),
    .game_status (game_status),
    .green_win   (green_win),
    .red_win     (red_win),
    .disp_mode   (disp_mode),
    .winner      (winner),
    .snake_vis   (snake_vis),
    .restart_ok  (restart_ok),
    .frame_start (frame_start)
  );

  function automatic void model_reset();
    m_mode = 2'b00;
    m_win  = 2'b00;
    m_vis  = 1'b1;
    m_rok  = 1'b0;
    m_k    = -1;
  endfunction

  // One frame boundary: the display is a pure function of status and position within the DIE episode.
  function automatic void model_frame(input logic [1:0] gs, input logic gw, input logic rw);
    m_vis = 1'b1;
    m_rok = 1'b0;
    case (gs)
      2'b00: begin m_mode = 2'b00; m_win = 2'b00; m_k = -1; end
      2'b01, 2'b10: begin m_mode = 2'b01; m_win = 2'b00; m_k = -1; end
      default: begin
        if (m_k < 0) begin
          m_k   = 0;
          m_win = {rw, gw};
        end else begin
          m_k = m_k + 1;
        end
        if (m_k < FF) begin
          m_mode = 2'b10;
          m_vis  = ((m_k / BH) % 2) == 0;
        end else begin
          m_mode = 2'b11;
          m_rok  = (m_k - FF) >= BM;
        end
      end
    endcase
  endfunction

  // Drives one synthetic vsync frame with the given status; records frame_start around the fall.
  task automatic do_frame(input logic [1:0] gs, input logic gw, input logic rw);
    game_status = gs;
    green_win   = gw;
    red_win     = rw;
    vga_vs      = 1'b0;
    @(posedge clk);
    @(negedge clk);
    fs_pre   = frame_start;
    mode_pre = disp_mode;
    @(posedge clk);
    model_frame(gs, gw, rw);
    @(negedge clk);
    fs_post = frame_start;
    @(posedge clk);
    #1 vga_vs = 1'b1;
    repeat ($urandom_range(6, 2)) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; vga_vs = 1'b1; game_status = 2'b10; green_win = 1'b0; red_win = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++; if (disp_mode !== 2'b00) begin errors++; $display("FAIL reset_mode got %b want 00", disp_mode); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs got %b want 0", frame_start); end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if ({disp_mode, winner, snake_vis, restart_ok} !== 6'b000010) begin
      errors++; $display("FAIL idle_after_release got %b want 000010", {disp_mode, winner, snake_vis, restart_ok});
    end
    @(posedge clk); #1;
    do_frame(2'b10, 1'b0, 1'b0);
    checks++; if (fs_pre !== 1'b1) begin errors++; $display("FAIL first_fs_pulse got %b want 1", fs_pre); end
    checks++; if (mode_pre !== 2'b00) begin errors++; $display("FAIL mode_before_latency got %b want 00", mode_pre); end
    checks++; if (fs_post !== 1'b0) begin errors++; $display("FAIL fs_width got %b want 0", fs_post); end
    checks++; if (disp_mode !== 2'b01) begin errors++; $display("FAIL first_field got %b want 01", disp_mode); end
    do_frame(2'b11, 1'b0, 1'b1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++; if ({disp_mode, winner, snake_vis, restart_ok, frame_start} !== 7'b0000100) begin
      errors++; $display("FAIL async_reset got %b want 0000100", {disp_mode, winner, snake_vis, restart_ok, frame_start});
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_red_win();
    do_frame(2'b10, 1'b0, 1'b0);
    for (int i = 0; i < FF + BM + 3; i++) begin
      if (i == 0) do_frame(2'b11, 1'b0, 1'b1);
      else        do_frame(2'b11, 1'($urandom), 1'($urandom));
      checks++; if (disp_mode !== m_mode || snake_vis !== m_vis || restart_ok !== m_rok || winner !== m_win) begin
        errors++; $display("FAIL red_win frame %0d got mode=%b vis=%b rok=%b win=%b want mode=%b vis=%b rok=%b win=%b",
                           i, disp_mode, snake_vis, restart_ok, winner, m_mode, m_vis, m_rok, m_win);
      end
    end
    checks++; if (winner !== 2'b10) begin errors++; $display("FAIL red_banner_winner got %b want 10", winner); end
  endtask

  task automatic test_draw();
    do_frame(2'b01, 1'b0, 1'b0);
    do_frame(2'b11, 1'b1, 1'b1);
    checks++; if (winner !== 2'b11) begin errors++; $display("FAIL draw_entry got %b want 11", winner); end
    for (int i = 0; i < 3; i++) begin
      do_frame(2'b11, 1'b0, 1'b0);
      checks++; if (winner !== 2'b11 || disp_mode !== m_mode) begin
        errors++; $display("FAIL draw_hold %0d got win=%b mode=%b want win=11 mode=%b", i, winner, disp_mode, m_mode);
      end
    end
  endtask

  task automatic test_abort();
    do_frame(2'b10, 1'b0, 1'b0);
    do_frame(2'b11, 1'b1, 1'b0);
    do_frame(2'b11, 1'b1, 1'b0);
    game_status = 2'b00;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++; if (disp_mode !== 2'b10 || winner !== 2'b01) begin
      errors++; $display("FAIL abort_premature got mode=%b win=%b want mode=10 win=01", disp_mode, winner);
    end
    @(posedge clk); #1;
    do_frame(2'b00, 1'b0, 1'b0);
    checks++; if ({disp_mode, winner, restart_ok} !== 5'b00000) begin
      errors++; $display("FAIL abort_blank got %b want 00000", {disp_mode, winner, restart_ok});
    end
    do_frame(2'b10, 1'b0, 1'b0);
    for (int i = 0; i <= FF; i++) begin
      do_frame(2'b11, 1'b0, 1'b1);
      checks++; if (disp_mode !== ((i < FF) ? 2'b10 : 2'b11) || snake_vis !== m_vis) begin
        errors++; $display("FAIL fresh_freeze frame %0d got mode=%b vis=%b want mode=%b vis=%b",
                           i, disp_mode, snake_vis, (i < FF) ? 2'b10 : 2'b11, m_vis);
      end
    end
  endtask

  task automatic test_midframe_toggle();
    do_frame(2'b10, 1'b0, 1'b0);
    game_status = 2'b11; red_win = 1'b1;
    repeat (3) @(posedge clk);
    #1 game_status = 2'b10;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (disp_mode !== 2'b01) begin errors++; $display("FAIL toggle_midframe got %b want 01", disp_mode); end
    @(posedge clk); #1;
    do_frame(2'b10, 1'b0, 1'b0);
    checks++; if (disp_mode !== 2'b01 || snake_vis !== 1'b1) begin
      errors++; $display("FAIL toggle_next_frame got mode=%b vis=%b want 01 1", disp_mode, snake_vis);
    end
  endtask

  task automatic test_vs_held();
    int pulses;
    int run;
    int max_run;
    pulses = 0; run = 0; max_run = 0;
    game_status = 2'b11; green_win = 1'b1; red_win = 1'b0;
    vga_vs = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (frame_start === 1'b1) begin
        run++;
        if (run == 1) pulses++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
    end
    model_frame(2'b11, 1'b1, 1'b0);
    checks++; if (pulses !== 1) begin errors++; $display("FAIL held_vs_pulses got %0d want 1", pulses); end
    checks++; if (max_run !== 1) begin errors++; $display("FAIL held_vs_width got %0d want 1", max_run); end
    checks++; if (disp_mode !== m_mode || winner !== m_win) begin
      errors++; $display("FAIL held_vs_state got mode=%b win=%b want mode=%b win=%b", disp_mode, winner, m_mode, m_win);
    end
    @(posedge clk); #1 vga_vs = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    int r;
    logic [1:0] gs;
    for (int i = 0; i < 60; i++) begin
      r  = $urandom_range(0, 11);
      gs = (r == 0) ? 2'b00 : (r < 3) ? 2'($urandom_range(1, 2)) : 2'b11;
      do_frame(gs, 1'($urandom), 1'($urandom));
      checks++; if (fs_pre !== 1'b1 || fs_post !== 1'b0) begin
        errors++; $display("FAIL rand_fs frame %0d got %b%b want 10", i, fs_pre, fs_post);
      end
      checks++; if (disp_mode !== m_mode || snake_vis !== m_vis || restart_ok !== m_rok ||
                    (m_mode != 2'b01 && winner !== m_win)) begin
        errors++; $display("FAIL rand frame %0d gs=%b got mode=%b vis=%b rok=%b win=%b want mode=%b vis=%b rok=%b win=%b",
                           i, gs, disp_mode, snake_vis, restart_ok, winner, m_mode, m_vis, m_rok, m_win);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_red_win();
    test_draw();
    test_abort();
    test_midframe_toggle();
    test_vs_held();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
